// File: rtl/lock_if.sv
// lock_if: keypad lock bus; master drives key_valid/key, slave returns state, seq, cnt, tries_left, lockout_rem, unlock_pulse, fail_pulse
interface lock_if #(
  parameter int DIGITS    = 8,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT   = 500
);
  logic                            key_valid;
  logic [4:0]                      key;
  logic [1:0]                      state;
  logic [4*DIGITS-1:0]             seq;
  logic [$clog2(DIGITS+1)-1:0]     cnt;
  logic [$clog2(MAX_TRIES+1)-1:0]  tries_left;
  logic [$clog2(LOCKOUT+1)-1:0]    lockout_rem;
  logic                            unlock_pulse;
  logic                            fail_pulse;
  modport master (
    output key_valid, key,
    input  state, seq, cnt, tries_left, lockout_rem, unlock_pulse, fail_pulse
  );
  modport slave (
    input  key_valid, key,
    output state, seq, cnt, tries_left, lockout_rem, unlock_pulse, fail_pulse
  );
endinterface

// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad lock FSM (clk, rst_n async active-low, lock_if.slave bus: key strobes in; state/seq/cnt/tries_left/lockout_rem/pulses out); define LOCK_REPROG_EN to allow code reprogramming while OPEN
module lock_ctrl #(
  parameter int                  DIGITS    = 8,
  parameter int                  MAX_TRIES = 3,
  parameter int                  LOCKOUT   = 500,
  parameter logic [4*DIGITS-1:0] CODE      = 32'h12345678
) (
  input  logic   clk,
  input  logic   rst_n,
  lock_if.slave  bus
);
  localparam int SW = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam int TW = $clog2(MAX_TRIES+1);
  localparam int LW = $clog2(LOCKOUT+1);
  typedef enum logic [1:0] {LOCKED = 2'd0, OPEN = 2'd1, ALARM = 2'd2} state_t;
  state_t          st, st_d;
  logic [SW-1:0]   seq_q, seq_d, code;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [LW-1:0]   lrem_q, lrem_d;
  logic            unl_q, unl_d, fail_q, fail_d, entry, full;
`ifdef LOCK_REPROG_EN
  localparam bit REPROG = 1'b1;
  logic [SW-1:0] code_q, code_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) code_q <= CODE;
    else        code_q <= code_d;
  assign code = code_q;
`else
  localparam bit REPROG = 1'b0;
  assign code = CODE;
`endif
  assign entry = st == LOCKED || (REPROG && st == OPEN);
  assign full  = cnt_q == CW'(DIGITS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= LOCKED;
      seq_q   <= '0;
      cnt_q   <= '0;
      tries_q <= TW'(MAX_TRIES);
      lrem_q  <= '0;
      unl_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      st      <= st_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      lrem_q  <= lrem_d;
      unl_q   <= unl_d;
      fail_q  <= fail_d;
    end
  always_comb begin
    st_d    = st;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    lrem_d  = lrem_q;
    unl_d   = 1'b0;
    fail_d  = 1'b0;
`ifdef LOCK_REPROG_EN
    code_d  = code_q;
`endif
    if (st == ALARM) begin
      lrem_d = lrem_q - 1'b1;
      if (lrem_q == LW'(1)) begin
        st_d    = LOCKED;
        tries_d = TW'(MAX_TRIES);
      end
    end else if (bus.key_valid && entry && !bus.key[4]) begin
      if (!full) begin
        seq_d = SW'({seq_q, bus.key[3:0]});
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.key_valid && entry && bus.key == 5'h11) begin
      seq_d = '0;
      cnt_d = '0;
    end else if (bus.key_valid && bus.key == 5'h10 && !(st == LOCKED && cnt_q == '0)) begin
      seq_d = '0;
      cnt_d = '0;
      if (st == OPEN) begin
        // a partial entry only discards itself; empty or full entry relocks
        st_d = (REPROG && cnt_q != '0 && !full) ? OPEN : LOCKED;
`ifdef LOCK_REPROG_EN
        code_d = full ? seq_q : code_q;
`endif
      end else if (full && seq_q == code) begin
        st_d    = OPEN;
        unl_d   = 1'b1;
        tries_d = TW'(MAX_TRIES);
      end else begin
        fail_d  = 1'b1;
        tries_d = tries_q - 1'b1;
        if (tries_q == TW'(1)) begin
          st_d   = ALARM;
          lrem_d = LW'(LOCKOUT);
        end
      end
    end
  end
  assign bus.state        = st;
  assign bus.seq          = seq_q;
  assign bus.cnt          = cnt_q;
  assign bus.tries_left   = tries_q;
  assign bus.lockout_rem  = lrem_q;
  assign bus.unlock_pulse = unl_q;
  assign bus.fail_pulse   = fail_q;
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: table-driven and scoreboarded checks of lock_ctrl with default parameters
module tb_lock_ctrl;
  typedef struct {
    logic        kv;
    logic [4:0]  key;
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic [31:0] seq;
    logic [1:0]  tries;
    logic        unl;
    logic        fail;
    logic [8:0]  lrem;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lock_if bus ();
  lock_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  function automatic vec_t mk(logic kv, logic [4:0] k, logic [1:0] st, logic [3:0] c, logic [31:0] s,
                              logic [1:0] t, logic u = 1'b0, logic f = 1'b0, logic [8:0] l = 9'd0);
    vec_t r;
    r.kv = kv; r.key = k; r.st = st; r.cnt = c; r.seq = s; r.tries = t; r.unl = u; r.fail = f; r.lrem = l;
    return r;
  endfunction
  task automatic v(logic kv, logic [4:0] k, logic [1:0] st, logic [3:0] c, logic [31:0] s,
                   logic [1:0] t, logic u = 1'b0, logic f = 1'b0);
    vecs.push_back(mk(kv, k, st, c, s, t, u, f));
  endtask
  // digits of val taken most-significant first; acc=0 means the digits must be ignored
  task automatic add_keys(logic [63:0] val, int n, logic [1:0] st, logic [1:0] t, bit acc);
    logic [31:0] s = '0;
    logic [3:0]  d;
    int c = 0;
    for (int i = 0; i < n; i++) begin
      d = val[4*(n-1-i) +: 4];
      if (acc && c < 8) begin
        s = {s[27:0], d};
        c++;
      end
      v(1'b1, {1'b0, d}, st, 4'(c), s, t);
    end
  endtask
  task automatic compare(string name);
    vec_t e = sb.pop_front();
    checks++;
    if (bus.state !== e.st || bus.cnt !== e.cnt || bus.seq !== e.seq || bus.tries_left !== e.tries ||
        bus.unlock_pulse !== e.unl || bus.fail_pulse !== e.fail || bus.lockout_rem !== e.lrem) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%0d seq=%h tries=%0d unl=%b fail=%b lrem=%0d, want st=%0d cnt=%0d seq=%h tries=%0d unl=%b fail=%b lrem=%0d",
               name, bus.state, bus.cnt, bus.seq, bus.tries_left, bus.unlock_pulse, bus.fail_pulse, bus.lockout_rem,
               e.st, e.cnt, e.seq, e.tries, e.unl, e.fail, e.lrem);
    end
  endtask
  task automatic step(vec_t e, string name);
    @(negedge clk);
    bus.key_valid = e.kv;
    bus.key = e.key;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    compare(name);
  endtask
  task automatic lockout(string tag);
    for (int a = 0; a < 3; a++) begin
      step(mk(1'b1, 5'h07, 2'd0, 4'd1, 32'h7, 2'(3 - a)), $sformatf("%s_digit%0d", tag, a));
      step(a < 2 ? mk(1'b1, 5'h10, 2'd0, 4'd0, 32'h0, 2'(2 - a), 1'b0, 1'b1)
                 : mk(1'b1, 5'h10, 2'd2, 4'd0, 32'h0, 2'd0, 1'b0, 1'b1, 9'd500), $sformatf("%s_enter%0d", tag, a));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, bad, i;
    bus.key_valid = 1'b0;
    bus.key = 5'h0;
    add_keys(64'h12345678, 8, 2'd0, 2'd3, 1'b1);
    v(1, 5'h10, 1, 0, 0, 3, 1);
`ifdef LOCK_REPROG_EN
    v(1, 5'h05, 1, 1, 32'h5, 3);
`else
    v(1, 5'h05, 1, 0, 0, 3);
`endif
    v(1, 5'h11, 1, 0, 0, 3);
    v(1, 5'h10, 0, 0, 0, 3);
    add_keys(64'h123, 3, 2'd0, 2'd3, 1'b1);
    v(1, 5'h10, 0, 0, 0, 2, 0, 1);
    add_keys(64'h1234, 4, 2'd0, 2'd2, 1'b1);
    v(1, 5'h15, 0, 4, 32'h1234, 2);
    v(0, 5'h01, 0, 4, 32'h1234, 2);
    v(1, 5'h11, 0, 0, 0, 2);
    v(1, 5'h10, 0, 0, 0, 2);
    add_keys(64'h123456789, 9, 2'd0, 2'd2, 1'b1);
    v(1, 5'h10, 1, 0, 0, 3, 1);
`ifdef LOCK_REPROG_EN
    add_keys(64'hABCDEF01, 8, 2'd1, 2'd3, 1'b1);
    v(1, 5'h10, 0, 0, 0, 3);
    add_keys(64'h12345678, 8, 2'd0, 2'd3, 1'b1);
    v(1, 5'h10, 0, 0, 0, 2, 0, 1);
    add_keys(64'hABCDEF01, 8, 2'd0, 2'd2, 1'b1);
    v(1, 5'h10, 1, 0, 0, 3, 1);
`else
    add_keys(64'hABCDEF01, 8, 2'd1, 2'd3, 1'b0);
    v(1, 5'h10, 0, 0, 0, 3);
    add_keys(64'h12345678, 8, 2'd0, 2'd3, 1'b1);
    v(1, 5'h10, 1, 0, 0, 3, 1);
`endif
    v(1, 5'h10, 0, 0, 0, 3);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(1'b0, 5'h0, 2'd0, 4'd0, 32'h0, 2'd3));
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < vecs.size(); k++) step(vecs[k], $sformatf("vec%0d", k));
    lockout("lock1");
    n = 1;
    bad = 0;
    for (int c = 0; c < 600 && bus.state == 2'd2; c++) begin
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key = (c % 3 == 0) ? 5'h03 : (c % 3 == 1) ? 5'h10 : 5'h11;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      if (bus.state == 2'd2) begin
        n++;
        if (bus.cnt != 0 || bus.lockout_rem != 9'(501 - n)) bad++;
      end
    end
    checks++;
    if (n != 500) begin
      errors++;
      $display("FAIL alarm_len: got %0d ALARM samples, want 500", n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL alarm_hold: got %0d bad countdown/entry samples, want 0", bad);
    end
    sb.push_back(mk(1'b0, 5'h0, 2'd0, 4'd0, 32'h0, 2'd3));
    compare("alarm_exit");
    lockout("lock2");
    i = 0;
    while (i < 400 && bus.lockout_rem != 9'd250) begin
      @(posedge clk);
      #1;
      i++;
    end
    checks++;
    if (bus.lockout_rem != 9'd250) begin
      errors++;
      $display("FAIL reach250: got lockout_rem %0d, want 250", bus.lockout_rem);
    end
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(1'b0, 5'h0, 2'd0, 4'd0, 32'h0, 2'd3));
    compare("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    vecs.delete();
    add_keys(64'h12345678, 8, 2'd0, 2'd3, 1'b1);
    v(1, 5'h10, 1, 0, 0, 3, 1);
    for (int k = 0; k < vecs.size(); k++) step(vecs[k], $sformatf("post_reset%0d", k));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Parametrised keypad lock controller. Consumes one-cycle key strobes from the key synchroniser, assembles an N-digit hex entry, compares it against a stored code, and tracks failed attempts with a timed lockout. It replaces the fixed-width FSM plus sequence register pair and feeds the display block with state, entry digits and counters.

## Interface

Parameters:
- `DIGITS`, 8: code length in hex digits; ≥1.
- `MAX_TRIES`, 3: consecutive failed attempts allowed before lockout; ≥1.
- `LOCKOUT`, 500: lockout duration in `clk` cycles (5 s at 100 Hz); ≥1.
- `CODE`, 32'h12345678: reset code, width 4*DIGITS.

Ports:
- `clk`  in  1  system clock (100 Hz in the top level).
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe: `key` is valid this cycle.
- `key`  in  5  0x00–0x0F hex digit, 0x10 ENTER, 0x11 CLEAR, 0x12–0x1F ignored.
- `state`  out  2  0 LOCKED, 1 OPEN, 2 ALARM.
- `seq`  out  4*DIGITS  entry register; newest digit in [3:0].
- `cnt`  out  $clog2(DIGITS+1)  digits currently entered.
- `tries_left`  out  $clog2(MAX_TRIES+1)  remaining attempts.
- `lockout_rem`  out  $clog2(LOCKOUT+1)  lockout cycles remaining; 0 outside ALARM.
- `unlock_pulse`  out  1  one cycle high on successful unlock.
- `fail_pulse`  out  1  one cycle high on each failed attempt.

## Operation

- Reset values: state LOCKED, seq 0, cnt 0, tries_left MAX_TRIES, lockout_rem 0, pulses 0, internal code register = CODE.
- Digit entry (LOCKED, or OPEN with REPROG_EN):
  - If cnt < DIGITS: seq <= {seq[4*DIGITS-5:0], key[3:0]}; cnt+1.
  - If cnt == DIGITS: digit dropped; seq and cnt unchanged.
- CLEAR in LOCKED or OPEN: seq and cnt go to 0. Consumes no attempt.
- LOCKED, ENTER:
  - cnt == 0: ignored; no attempt consumed.
  - cnt == DIGITS and seq == code: go to OPEN, unlock_pulse, tries_left reset to MAX_TRIES.
  - Any other cnt: fail_pulse and tries_left−1.
    - If the decremented value is 0: go to ALARM, lockout_rem = LOCKOUT.
    - Otherwise stay LOCKED.
  - seq and cnt clear on every ENTER that is not ignored.
- OPEN, ENTER:
  - cnt == 0: relock to LOCKED; code unchanged.
  - cnt == DIGITS (REPROG_EN only): code register <= seq; go to LOCKED.
  - 0 < cnt < DIGITS: entry cleared; stay OPEN; code unchanged.
  - seq and cnt clear in all three cases.
- ALARM:
  - All keys ignored; seq and cnt held at 0.
  - lockout_rem decrements every cycle.
  - On the cycle lockout_rem == 1: next state LOCKED, lockout_rem 0, tries_left MAX_TRIES.
- Ignored key codes (0x12–0x1F) have no effect in any state.

## Timing

- All outputs registered. A key strobed in cycle N is reflected in outputs after edge N+1.
- `unlock_pulse` and `fail_pulse` are high exactly one cycle, coincident with the state/counter update.
- ALARM is held for exactly LOCKOUT cycles: `state`==2 for LOCKOUT consecutive samples.
- `key_valid` on back-to-back cycles: each strobe is processed; no minimum spacing.
- `key_valid` low: no state change, except the ALARM countdown.
- Reset asserted mid-entry or mid-lockout: immediate return to reset values, including the code register reverting to CODE.

## Configuration

- `LOCK_REPROG_EN` defined:
  - Digits are accepted in OPEN.
  - A full DIGITS-digit entry followed by ENTER overwrites the code register and relocks.
- Undefined:
  - Digits and CLEAR are ignored in OPEN; ENTER always relocks.
  - The code register is constant CODE; no reprogramming logic is synthesised.

## Test plan

- Reset, keys 1,2,3,4,5,6,7,8, ENTER -> state 1, unlock_pulse once, tries_left 3, cnt 0.
- Keys 1,2,3 then ENTER in LOCKED -> fail_pulse, tries_left 2, state 0. Repeat twice -> state 2, lockout_rem 500, then state 0 with tries_left 3 exactly 500 cycles later.
- Nine digits 1..9 -> cnt 8, seq 32'h12345678 (ninth dropped). ENTER alone with cnt 0 -> no fail_pulse.
- LOCK_REPROG_EN: unlock, enter A,B,C,D,E,F,0,1, ENTER -> state 0. Old code fails; 32'hABCDEF01 unlocks. Without the macro the same sequence relocks and CODE still unlocks.
- Key 0x11 after 4 digits -> cnt 0, seq 0, tries_left unchanged. Key 0x15 -> no output change.
- rst_n low for one cycle during ALARM with lockout_rem 250 -> state 0, lockout_rem 0, tries_left 3, code = CODE.
